// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the APB master bridge: FSM state type and the
// helper that sizes the wait-state counter from the timeout setting.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apbState_e;

    // Bits needed to hold 0..timeoutCycles, never less than one bit so a
    // disabled timeout still yields a legal vector.
    function automatic int cntWidth(input int timeoutCycles);
        if (timeoutCycles < 1) begin
            return 1;
        end
        return $clog2(timeoutCycles + 1);
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Wait-state counter for the APB ACCESS phase. Counts cycles in which the
// slave stalls, saturates at the limit, and flags the stall that would make
// the count reach the limit. A limit of zero disables expiry.
module apb_timeout_cnt #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic [CNT_WIDTH-1:0] limit_i,
    output logic                 expired_o
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;
    logic                 atLimit;

    assign atLimit = (count_q == limit_i);

    // Expiry fires on the stall cycle that completes the allowed number of
    // wait cycles, so the master can leave ACCESS on the following edge.
    assign expired_o = enable_i && (limit_i != '0)
                       && (count_q == (limit_i - CNT_WIDTH'(1)));

    // Next count: clear wins, otherwise step on a stall until saturated.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !atLimit) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding bridge from a simple req/gnt core port to an APB
// master. All APB controls and the response strobe come straight from
// flops so the bus sees glitch-free signals.
module apb_master_bridge
    import apb_bridge_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    localparam int CntW = cntWidth(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] TimeoutLimit = CntW'(TIMEOUT_CYCLES);

    apbState_e                 state_q;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic                      write_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic                      psel_q;
    logic                      penable_q;
    logic                      rvalid_q;
    logic                      err_q;
    logic [APB_DATA_WIDTH-1:0] rdata_q;

    logic grant;
    logic cntEnable;
    logic cntExpired;

    // Accept only from IDLE; reset also masks the grant.
    assign grant     = req_i && (state_q == IDLE) && !rst_i;
    assign cntEnable = (state_q == ACCESS) && !pready_i;

    apb_timeout_cnt #(
        .CNT_WIDTH (CntW)
    ) u_timeout_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (grant),
        .enable_i  (cntEnable),
        .limit_i   (TimeoutLimit),
        .expired_o (cntExpired)
    );

    assign gnt_o     = grant;
    assign psel_o    = psel_q;
    assign penable_o = penable_q;
    assign pwrite_o  = write_q;
    assign paddr_o   = addr_q;
    assign pwdata_o  = wdata_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;

    // Transaction FSM with registered APB controls and one-cycle response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        addr_q  <= addr_i;
                        write_q <= we_i;
                        wdata_q <= wdata_i;
                        psel_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (pready_i) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        err_q     <= pslverr_i;
                        rdata_q   <= write_q ? '0 : prdata_i;
                        state_q   <= IDLE;
                    end else if (cntExpired) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        err_q     <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 32, meaning PADDR/request address width.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, meaning PWDATA/PRDATA width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max ACCESS cycles before abort (0 = timeout disabled).
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-high.
REQ-006 req_i  in  1  request valid from upstream core-side port.
REQ-007 gnt_o  out  1  request accepted this cycle.
REQ-008 addr_i  in  APB_ADDR_WIDTH  request address.
REQ-009 we_i  in  1  1 = write, 0 = read.
REQ-010 wdata_i  in  APB_DATA_WIDTH  write data.
REQ-011 rvalid_o  out  1  one-cycle response strobe.
REQ-012 rdata_o  out  APB_DATA_WIDTH  read data, valid with rvalid_o.
REQ-013 err_o  out  1  error flag, valid with rvalid_o.
REQ-014 psel_o, penable_o, pwrite_o  out  1 each  APB master controls, feeding the APB node slave port.
REQ-015 paddr_o  out  APB_ADDR_WIDTH; pwdata_o  out  APB_DATA_WIDTH.
REQ-016 prdata_i  in  APB_DATA_WIDTH; pready_i  in  1; pslverr_i  in  1  APB response from the node.

Function
REQ-017 SHALL implement FSM with states IDLE, SETUP, ACCESS; at most one transaction outstanding.
REQ-018 gnt_o SHALL be combinational: gnt_o = req_i AND state==IDLE AND NOT rvalid_o pending condition absent (i.e. only state==IDLE).
REQ-019 On gnt_o, SHALL register addr_i, we_i, wdata_i and go IDLE->SETUP.
REQ-020 SETUP: psel_o=1, penable_o=0; SHALL always go SETUP->ACCESS after exactly one cycle.
REQ-021 ACCESS: psel_o=1, penable_o=1; SHALL stay until pready_i=1 or timeout, then go ACCESS->IDLE.
REQ-022 paddr_o, pwrite_o, pwdata_o SHALL be stable from SETUP through final ACCESS cycle and hold last value in IDLE.
REQ-023 On ACCESS with pready_i=1, SHALL assert rvalid_o the next cycle for exactly one cycle, err_o=pslverr_i, rdata_o=prdata_i for reads, 0 for writes.
REQ-024 Minimum latency: gnt cycle N, SETUP N+1, ACCESS N+2, rvalid_o N+3; next gnt_o possible at N+3.
REQ-025 Wait-state counter SHALL clear on SETUP entry and increment each ACCESS cycle with pready_i=0, saturating at TIMEOUT_CYCLES.
REQ-026 If TIMEOUT_CYCLES>0 and counter reaches TIMEOUT_CYCLES with pready_i=0, SHALL drop psel_o/penable_o next cycle, return to IDLE, pulse rvalid_o with err_o=1, rdata_o=0.
REQ-027 pready_i in the same cycle timeout is reached SHALL win (normal completion).
REQ-028 pready_i, pslverr_i, prdata_i SHALL be ignored outside ACCESS.
REQ-029 Counter width SHALL be $clog2(TIMEOUT_CYCLES+1), minimum 1.

Reset
REQ-030 rst_i SHALL force IDLE, counter 0, captured registers 0.
REQ-031 During reset: psel_o=0, penable_o=0, pwrite_o=0, paddr_o=0, pwdata_o=0, rvalid_o=0, rdata_o=0, err_o=0, gnt_o=0.
REQ-032 Reset mid-transaction SHALL abort immediately with no response pulse after release.

Structure
REQ-033 FSM state typedef (IDLE/SETUP/ACCESS) SHALL live in shared package apb_bridge_pkg.
REQ-034 Wait-state/timeout counter SHALL be sub-module apb_timeout_cnt (clear, enable, limit, expired).
REQ-035 psel_o/penable_o SHALL be decoded from registered state, glitch-free.

Verification
REQ-036 Write 0x1A00_0004 data 0xDEAD_BEEF, pready_i=1 at first ACCESS -> gnt N, psel N+1, penable N+2, rvalid_o N+3, err_o=0.
REQ-037 Read 0x1A10_0000, pready_i low 3 ACCESS cycles then high with prdata_i=0x1234_5678 -> rvalid_o once, rdata_o=0x1234_5678, addr stable throughout.
REQ-038 Read with pslverr_i=1 at completion -> rvalid_o with err_o=1.
REQ-039 TIMEOUT_CYCLES=4, pready_i held 0 -> psel_o drops after 4 wait cycles, rvalid_o with err_o=1, rdata_o=0.
REQ-040 req_i held high continuously -> gnt_o only when IDLE, back-to-back spacing 3 cycles, no lost/duplicated response.
REQ-041 rst_i asserted during ACCESS -> all outputs 0 asynchronously, no rvalid_o after release.
